buf_drive_char_seq: RTL
=======================

// Module: buf_drive_char_seq
// PURPOSE
//  Sequencer for buffer drive-strength characterization. Selects one buffer variant at
//  a time (X1..X32) onto the shared output net and drives a toggle pattern into it.
//  Compares the captured DFF output against the expected delayed pattern and reports a
//  per-cell mismatch count over a valid/ready handshake. Sits between the test
//  controller and the buffer/capture-flop structure under characterization.
// PARAMETERS
//  NUM_CELLS     6   number of buffer variants; index 0 = X1 ... 5 = X32
//  SEL_W         3   width of cell index, >= clog2(NUM_CELLS)
//  SETTLE_CYCLES 4   idle cycles after selecting a cell, before launch (>=1)
//  PATTERN_LEN   16  launched bits per cell (>=1)
//  CAPTURE_LAT   2   cycles from launch_d to matching capture_q (>=1)
//  CNT_W         8   width of the mismatch counter
// PORTS
//  clk         in   1          single clock, rising edge
//  rst_n       in   1          asynchronous active-low reset
//  start       in   1          begin sweep; sampled only in IDLE
//  abort       in   1          cancel sweep; wins over every other event
//  cell_mask   in   NUM_CELLS  1 = characterize cell i; sampled at start
//  sel_onehot  out  NUM_CELLS  enable of selected buffer; all zero when none
//  launch_d    out  1          pattern bit into selected buffer
//  capture_q   in   1          capture-flop Q returned from datapath
//  busy        out  1          high in every state except IDLE
//  done        out  1          1-cycle pulse on sweep completion
//  res_valid   out  1          result available
//  res_ready   in   1          consumer accepts result
//  res_cell    out  SEL_W      cell index of result
//  res_errs    out  CNT_W      mismatches for that cell, saturating
// BEHAVIOUR
//  Reset: state=IDLE; all outputs 0; latched mask 0; counters 0.
//  FSM: IDLE -> SETTLE -> RUN -> DRAIN -> REPORT -> (SETTLE of next cell | IDLE).
//  IDLE
//   - On start with a nonzero mask: latch the mask, pick the lowest set index, go to SETTLE.
//   - On start with a zero mask: done pulses on the next cycle; stays IDLE; no results.
//  SETTLE
//   - sel_onehot = 1<<cell; launch_d = 0; lasts exactly SETTLE_CYCLES cycles.
//  RUN
//   - Lasts PATTERN_LEN cycles k = 0..N-1; launch_d = ~k[0] (pattern 1,0,1,0...).
//  DRAIN
//   - Lasts CAPTURE_LAT cycles; launch_d = 0; sel_onehot is still held.
//  Compare
//   - Bit k is checked against capture_q sampled CAPTURE_LAT cycles after its launch.
//   - Exactly PATTERN_LEN compares per cell, landing in RUN tail and DRAIN.
//   - Each mismatch increments the error counter; it saturates at 2^CNT_W-1 and clears on entering SETTLE.
//  REPORT
//   - sel_onehot = 0; res_valid = 1; res_cell and res_errs are held stable until res_valid&&res_ready.
//   - On handshake: res_valid drops the next cycle and the FSM moves to the next higher set
//     mask bit (SETTLE).
//   - If no set bit remains: go to IDLE with done pulsed on the cycle IDLE is entered.
//  Start while busy: ignored. Mask changes while busy: ignored.
//  Abort (any non-IDLE state)
//   - Next cycle: IDLE, sel_onehot=0, launch_d=0, res_valid=0.
//   - No done pulse; any pending result is discarded.
//  rst_n low mid-sweep: immediate return to reset values; no done pulse.
//  Exactly one sel_onehot bit is set during SETTLE/RUN/DRAIN; never more than one.
// TESTING
//  1. mask=6'h3F, capture_q = launch_d delayed 2, res_ready=1
//     -> 6 results, cells 0..5 in order, errs 0 each; done once.
//  2. As 1, but capture_q stuck 0 while sel_onehot[3]
//     -> cell 3 errs=8, all others 0.
//  3. mask=6'b100100 -> results only for cells 2 then 5; sel_onehot never 6'h01/02/08/10/01.
//  4. res_ready low 10 cycles in REPORT
//     -> res_valid held, res_cell/res_errs stable, sel_onehot=0; advances after ready.
//  5. abort in RUN cycle 5 of cell 1 -> IDLE next cycle, all outputs 0, no done;
//     a new start with mask=1 completes normally.
//  6. mask=0 start -> done pulse 1 cycle later, no res_valid.
//     Separately, rst_n low mid-DRAIN -> outputs 0 asynchronously.

Source files
------------

// File: rtl/buf_drive_char_seq.sv
// Drive-strength characterization sequencer: steps through masked buffer variants,
// launches a 1010.. pattern, and counts capture mismatches for each cell.
module buf_drive_char_seq #(
  parameter int NUM_CELLS     = 6,
  parameter int SEL_W         = 3,
  parameter int SETTLE_CYCLES = 4,
  parameter int PATTERN_LEN   = 16,
  parameter int CAPTURE_LAT   = 2,
  parameter int CNT_W         = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic                 abort,
  input  logic [NUM_CELLS-1:0] cell_mask,
  output logic [NUM_CELLS-1:0] sel_onehot,
  output logic                 launch_d,
  input  logic                 capture_q,
  output logic                 busy,
  output logic                 done,
  output logic                 res_valid,
  input  logic                 res_ready,
  output logic [SEL_W-1:0]     res_cell,
  output logic [CNT_W-1:0]     res_errs
);

  localparam int MAX_A = (SETTLE_CYCLES > PATTERN_LEN) ? SETTLE_CYCLES : PATTERN_LEN;
  localparam int MAXC  = (MAX_A > CAPTURE_LAT) ? MAX_A : CAPTURE_LAT;
  localparam int CW    = $clog2(MAXC + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_SETTLE, S_RUN, S_DRAIN, S_REPORT
  } state_t;

  state_t                 state_q, state_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic [SEL_W-1:0]       cell_q, cell_d;
  logic [NUM_CELLS-1:0]   mask_q, mask_d;
  logic [CNT_W-1:0]       err_q, err_d;
  logic                   done_q, done_d;
  logic [CAPTURE_LAT-1:0] pv_q, pv_d;
  logic [CAPTURE_LAT-1:0] pb_q, pb_d;

  logic                   first_found, nxt_found;
  logic [SEL_W-1:0]       first_idx, nxt_idx;
  logic                   run_v, run_b, mismatch;

  // Lowest set bit of the incoming mask, and next set latched bit above the current cell.
  always_comb begin
    first_found = 1'b0;
    first_idx   = '0;
    nxt_found   = 1'b0;
    nxt_idx     = '0;
    for (int unsigned i = 0; i < NUM_CELLS; i++) begin
      if (!first_found && cell_mask[i]) begin
        first_found = 1'b1;
        first_idx   = SEL_W'(i);
      end
      if (!nxt_found && mask_q[i] && (i > 32'(cell_q))) begin
        nxt_found = 1'b1;
        nxt_idx   = SEL_W'(i);
      end
    end
  end

  // Launched bits travel down a valid/bit delay line so each lands on its own capture cycle.
  assign run_v    = (state_q == S_RUN);
  assign run_b    = run_v & ~cnt_q[0];
  assign mismatch = pv_q[CAPTURE_LAT-1] && (pb_q[CAPTURE_LAT-1] != capture_q);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      cell_q  <= '0;
      mask_q  <= '0;
      err_q   <= '0;
      done_q  <= 1'b0;
      pv_q    <= '0;
      pb_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      cell_q  <= cell_d;
      mask_q  <= mask_d;
      err_q   <= err_d;
      done_q  <= done_d;
      pv_q    <= pv_d;
      pb_q    <= pb_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + CW'(1);
    cell_d  = cell_q;
    mask_d  = mask_q;
    done_d  = 1'b0;
    err_d   = (mismatch && (err_q != '1)) ? err_q + CNT_W'(1) : err_q;
    pv_d    = (pv_q << 1) | CAPTURE_LAT'(run_v);
    pb_d    = (pb_q << 1) | CAPTURE_LAT'(run_b);

    case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        if (start) begin
          if (first_found) begin
            state_d = S_SETTLE;
            mask_d  = cell_mask;
            cell_d  = first_idx;
            err_d   = '0;
          end else begin
            done_d = 1'b1;
          end
        end
      end
      S_SETTLE: begin
        if (cnt_q == CW'(SETTLE_CYCLES - 1)) begin
          state_d = S_RUN;
          cnt_d   = '0;
        end
      end
      S_RUN: begin
        if (cnt_q == CW'(PATTERN_LEN - 1)) begin
          state_d = S_DRAIN;
          cnt_d   = '0;
        end
      end
      S_DRAIN: begin
        if (cnt_q == CW'(CAPTURE_LAT - 1)) begin
          state_d = S_REPORT;
          cnt_d   = '0;
        end
      end
      S_REPORT: begin
        cnt_d = '0;
        if (res_ready) begin
          if (nxt_found) begin
            state_d = S_SETTLE;
            cell_d  = nxt_idx;
            err_d   = '0;
          end else begin
            state_d = S_IDLE;
            mask_d  = '0;
            cell_d  = '0;
            done_d  = 1'b1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (abort && (state_q != S_IDLE)) begin
      state_d = S_IDLE;
      cnt_d   = '0;
      cell_d  = '0;
      mask_d  = '0;
      err_d   = '0;
      done_d  = 1'b0;
      pv_d    = '0;
      pb_d    = '0;
    end
  end

  always_comb begin
    sel_onehot = '0;
    launch_d   = 1'b0;
    res_valid  = 1'b0;
    res_cell   = '0;
    res_errs   = '0;
    busy       = (state_q != S_IDLE);
    done       = done_q;
    case (state_q)
      S_SETTLE, S_DRAIN: sel_onehot = NUM_CELLS'(1) << cell_q;
      S_RUN: begin
        sel_onehot = NUM_CELLS'(1) << cell_q;
        launch_d   = ~cnt_q[0];
      end
      S_REPORT: begin
        res_valid = 1'b1;
        res_cell  = cell_q;
        res_errs  = err_q;
      end
      default: ;
    endcase
  end

endmodule
